lvt_wr_sched: RTL and testbench
===============================

// Module: lvt_wr_sched
// PURPOSE
//  Write scheduler placed directly upstream of the 2-read/4-write LVT RAM.
//  It takes write requests on 4 valid/ready lanes and queues each lane in its own FIFO.
//  Each cycle it drives the RAM's 4 write ports (w_addr_k/w_din_k/w_enb_k) from the FIFO heads.
//  Same-cycle same-address writes are serialised, so the LVT never sees a multi-port conflict.
// PARAMETERS
//  BLOCKSIZE   10  address is BLOCKSIZE+1 bits wide; must match the downstream RAM.
//  FIFO_DEPTH  4   entries per lane FIFO; power of 2, >=2.
//  DATA_W      32  write data width.
// PORTS
//  clk         in   1            clock; all state changes on posedge.
//  rst         in   1            asynchronous reset, active-high.
//  in_valid_k  in   1            lane k request valid (k=1..4).
//  in_ready_k  out  1            lane k can accept a request; equals !full_k (combinational).
//  in_addr_k   in   BLOCKSIZE+1  lane k write address.
//  in_data_k   in   DATA_W       lane k write data.
//  w_enb_k     out  1            registered write enable to RAM port k.
//  w_addr_k    out  BLOCKSIZE+1  registered write address to RAM port k.
//  w_din_k     out  DATA_W       registered write data to RAM port k.
//  idle        out  1            1 when all FIFOs are empty and all w_enb_k are 0.
//  coll_cnt    out  16           collision count; exists only with WSCHED_COLL_CNT_EN.
// BEHAVIOUR
//  Reset (async, active-high):
//   - FIFO pointers and count go to 0 and all FIFOs are empty.
//   - w_enb_k, w_addr_k, w_din_k and coll_cnt go to 0; idle=1; in_ready_k=1.
//   - Reset mid-operation drops all queued requests.
//  Enqueue: lane k enqueues at posedge when in_valid_k & in_ready_k.
//   - When a FIFO is full, in_ready_k stays 0 even if the same cycle dequeues.
//  Issue (per cycle, evaluated on FIFO heads before the edge):
//   - head_k is eligible if FIFO k is non-empty.
//   - head_k issues unless an eligible lane j<k has an equal address.
//   - So the lowest-numbered lane wins each address; blocked heads stay put.
//   - Issuing lane k at posedge: w_enb_k<=1, w_addr_k<=head addr, w_din_k<=head data, pop.
//   - Non-issuing lane k: w_enb_k<=0; w_addr_k and w_din_k hold their values.
//  Latency:
//   - A request enqueued at edge N, with no collision, appears on w_*_k after edge N+1.
//   - There is no bypass path.
//   - Throughput is 1 write/lane/cycle when there are no collisions.
//  Ordering:
//   - FIFO order is preserved within a lane.
//   - Across lanes, same-address order is by issue cycle, then lane index.
//   - After a collision, blocked lanes issue strictly later than the winner, so the LVT
//     records the last-issued lane.
//  Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//   - A separate count of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.
//  idle is combinational from the FIFO-empty flags and the registered w_enb_k.
// CONFIGURATION
//  WSCHED_COLL_CNT_EN defined:
//   - coll_cnt port is present.
//   - Increments by the number of lanes blocked in that cycle (0..3).
//   - Saturates at 16'hFFFF; cleared only by rst.
//  WSCHED_COLL_CNT_EN undefined:
//   - coll_cnt port and its logic are absent; all other behaviour is identical.
// TESTING
//  T1 Single write: lane1 addr=0x005, data=0xA5A5A5A5 for one cycle
//     -> one cycle later w_enb_1=1, w_addr_1=0x005, w_din_1=0xA5A5A5A5 for exactly 1 cycle;
//        then idle=1.
//  T2 Four distinct addrs 0x001..0x004 on lanes 1..4 in the same cycle
//     -> all four w_enb_k=1 in the same cycle with matching addr/data; coll_cnt=0.
//  T3 Lanes 1,3,4 all write addr 0x010 (data 1,3,4) in one cycle
//     -> cycle A: w_enb_1 only; cycle A+1: w_enb_3 only; cycle A+2: w_enb_4;
//        coll_cnt=3 (2+1).
//  T4 Hold in_valid_2=1 with a pushed collision blocking lane 2 (FIFO_DEPTH=4)
//     -> in_ready_2=0 after 4 accepts; no 5th entry is lost or duplicated once lane 2 drains.
//  T5 Push 10 sequential writes on lane 4, addr 0x000..0x009
//     -> they issue in order on w_*_4 with no gaps; pointer wrap is exercised.
//  T6 Assert rst while 3 entries are queued on lane 1
//     -> w_enb_*=0 immediately (async), idle=1, in_ready_*=1; no queued write issues after
//        rst deasserts.

Source files
------------

// File: rtl/lvt_wr_sched.sv
// Write scheduler for the 2R/4W LVT RAM: per-lane FIFOs, same-address heads serialised by lane order.
// Optional collision counter is built only when WSCHED_COLL_CNT_EN is defined.

module lvt_wr_sched_lane #(
  parameter int AW    = 11,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          issue,
  output logic          empty,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic          w_enb,
  output logic [AW-1:0] w_addr,
  output logic [DW-1:0] w_din
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]                wr_ptr, rd_ptr;
  logic [CW-1:0]                cnt;
  logic [DEPTH-1:0][AW-1:0]     addr_mem;
  logic [DEPTH-1:0][DW-1:0]     data_mem;
  logic                         push, pop;

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
  assign in_ready  = (cnt != CW'(DEPTH));
  assign empty     = (cnt == '0);
  assign push      = in_valid & in_ready;
  assign pop       = issue & ~empty;
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= in_addr;
      data_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      w_enb  <= 1'b0;
      w_addr <= '0;
      w_din  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt   <= cnt + CW'(push) - CW'(pop);
      w_enb <= pop;
      if (pop) begin
        w_addr <= head_addr;
        w_din  <= head_data;
      end
    end
  end
endmodule

module lvt_wr_sched #(
  parameter int BLOCKSIZE  = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_1,
  input  logic                 in_valid_2,
  input  logic                 in_valid_3,
  input  logic                 in_valid_4,
  output logic                 in_ready_1,
  output logic                 in_ready_2,
  output logic                 in_ready_3,
  output logic                 in_ready_4,
  input  logic [BLOCKSIZE:0]   in_addr_1,
  input  logic [BLOCKSIZE:0]   in_addr_2,
  input  logic [BLOCKSIZE:0]   in_addr_3,
  input  logic [BLOCKSIZE:0]   in_addr_4,
  input  logic [DATA_W-1:0]    in_data_1,
  input  logic [DATA_W-1:0]    in_data_2,
  input  logic [DATA_W-1:0]    in_data_3,
  input  logic [DATA_W-1:0]    in_data_4,
  output logic                 w_enb_1,
  output logic                 w_enb_2,
  output logic                 w_enb_3,
  output logic                 w_enb_4,
  output logic [BLOCKSIZE:0]   w_addr_1,
  output logic [BLOCKSIZE:0]   w_addr_2,
  output logic [BLOCKSIZE:0]   w_addr_3,
  output logic [BLOCKSIZE:0]   w_addr_4,
  output logic [DATA_W-1:0]    w_din_1,
  output logic [DATA_W-1:0]    w_din_2,
  output logic [DATA_W-1:0]    w_din_3,
  output logic [DATA_W-1:0]    w_din_4,
  output logic                 idle
`ifdef WSCHED_COLL_CNT_EN
  ,
  output logic [15:0]          coll_cnt
`endif
);
  localparam int NUM_LANES = 4;
  localparam int AW        = BLOCKSIZE + 1;

  logic [NUM_LANES-1:0]             vld, rdy, empty, blk, issue, enb;
  logic [NUM_LANES-1:0][AW-1:0]     addr, head_addr, waddr;
  logic [NUM_LANES-1:0][DATA_W-1:0] data, head_data, wdin;

  assign vld  = {in_valid_4, in_valid_3, in_valid_2, in_valid_1};
  assign addr = {in_addr_4, in_addr_3, in_addr_2, in_addr_1};
  assign data = {in_data_4, in_data_3, in_data_2, in_data_1};

  assign {in_ready_4, in_ready_3, in_ready_2, in_ready_1} = rdy;
  assign {w_enb_4, w_enb_3, w_enb_2, w_enb_1}             = enb;
  assign {w_addr_4, w_addr_3, w_addr_2, w_addr_1}         = waddr;
  assign {w_din_4, w_din_3, w_din_2, w_din_1}             = wdin;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lvt_wr_sched_lane #(.AW(AW), .DW(DATA_W), .DEPTH(FIFO_DEPTH)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .in_valid (vld[k]),
      .in_ready (rdy[k]),
      .in_addr  (addr[k]),
      .in_data  (data[k]),
      .issue    (issue[k]),
      .empty    (empty[k]),
      .head_addr(head_addr[k]),
      .head_data(head_data[k]),
      .w_enb    (enb[k]),
      .w_addr   (waddr[k]),
      .w_din    (wdin[k])
    );
  end

  // A head is held back by any eligible lower lane with the same address, even one itself blocked.
  always_comb begin
    blk = '0;
    for (int k = 1; k < NUM_LANES; k++)
      for (int j = 0; j < k; j++)
        if (!empty[j] && head_addr[j] == head_addr[k]) blk[k] = 1'b1;
  end

  assign issue = ~empty & ~blk;
  assign idle  = (&empty) & ~(|enb);

`ifdef WSCHED_COLL_CNT_EN
  logic [2:0]  nblk;
  logic [16:0] coll_sum;

  always_comb begin
    nblk = '0;
    for (int k = 0; k < NUM_LANES; k++)
      if (!empty[k] && blk[k]) nblk = nblk + 3'd1;
  end

  assign coll_sum = {1'b0, coll_cnt} + 17'(nblk);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) coll_cnt <= '0;
    else     coll_cnt <= coll_sum[16] ? 16'hFFFF : coll_sum[15:0];
  end
`endif
endmodule

// File: tb/tb_lvt_wr_sched.sv
// Randomised and directed bench for lvt_wr_sched against a queue-based model of the issue rules.
// Build with WSCHED_COLL_CNT_EN defined to also check coll_cnt.
module tb_lvt_wr_sched;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [10:0] a;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]       vin;
  logic [3:0][10:0] ain;
  logic [3:0][31:0] din;
  logic [3:0]       rdy, enb;
  logic [3:0][10:0] wa;
  logic [3:0][31:0] wd;
  logic             idle;
  logic             in_ready_1, in_ready_2, in_ready_3, in_ready_4;
  logic             w_enb_1, w_enb_2, w_enb_3, w_enb_4;
  logic [10:0]      w_addr_1, w_addr_2, w_addr_3, w_addr_4;
  logic [31:0]      w_din_1, w_din_2, w_din_3, w_din_4;
`ifdef WSCHED_COLL_CNT_EN
  logic [15:0]      coll_cnt;
  int               exp_coll;
`endif

  lvt_wr_sched #(.BLOCKSIZE(10), .FIFO_DEPTH(DEPTH), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid_1(vin[0]), .in_valid_2(vin[1]), .in_valid_3(vin[2]), .in_valid_4(vin[3]),
    .in_ready_1(in_ready_1), .in_ready_2(in_ready_2), .in_ready_3(in_ready_3), .in_ready_4(in_ready_4),
    .in_addr_1(ain[0]), .in_addr_2(ain[1]), .in_addr_3(ain[2]), .in_addr_4(ain[3]),
    .in_data_1(din[0]), .in_data_2(din[1]), .in_data_3(din[2]), .in_data_4(din[3]),
    .w_enb_1(w_enb_1), .w_enb_2(w_enb_2), .w_enb_3(w_enb_3), .w_enb_4(w_enb_4),
    .w_addr_1(w_addr_1), .w_addr_2(w_addr_2), .w_addr_3(w_addr_3), .w_addr_4(w_addr_4),
    .w_din_1(w_din_1), .w_din_2(w_din_2), .w_din_3(w_din_3), .w_din_4(w_din_4),
    .idle(idle)
`ifdef WSCHED_COLL_CNT_EN
    , .coll_cnt(coll_cnt)
`endif
  );

  assign rdy = {in_ready_4, in_ready_3, in_ready_2, in_ready_1};
  assign enb = {w_enb_4, w_enb_3, w_enb_2, w_enb_1};
  assign wa  = {w_addr_4, w_addr_3, w_addr_2, w_addr_1};
  assign wd  = {w_din_4, w_din_3, w_din_2, w_din_1};

  int checks = 0;
  int errors = 0;

  ent_t             q [4][$];
  logic [3:0]       exp_enb  = '0;
  logic [3:0][10:0] exp_addr = '0;
  logic [3:0][31:0] exp_din  = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_idle();
    bit e = (exp_enb == '0);
    for (int k = 0; k < 4; k++) if (q[k].size() != 0) e = 0;
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) q[k].delete();
    exp_enb  = '0;
    exp_addr = '0;
    exp_din  = '0;
`ifdef WSCHED_COLL_CNT_EN
    exp_coll = 0;
`endif
  endtask

  // Check the outputs produced by the last edge, then predict the next edge from vin/ain/din.
  task automatic step();
    logic [10:0] used[$];
    logic [3:0]  acc;
    ent_t        h;
    bit          hit;
    int          nb;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("enb%0d", k + 1), enb[k], exp_enb[k]);
      chk($sformatf("addr%0d", k + 1), wa[k], exp_addr[k]);
      chk($sformatf("din%0d", k + 1), wd[k], exp_din[k]);
      chk($sformatf("rdy%0d", k + 1), rdy[k], q[k].size() < DEPTH);
    end
    chk("idle", idle, model_idle());
`ifdef WSCHED_COLL_CNT_EN
    chk("coll", coll_cnt, exp_coll);
`endif
    nb = 0;
    for (int k = 0; k < 4; k++) acc[k] = vin[k] && (q[k].size() < DEPTH);
    for (int k = 0; k < 4; k++) begin
      exp_enb[k] = 1'b0;
      if (q[k].size() != 0) begin
        h   = q[k][0];
        hit = 0;
        foreach (used[i]) if (used[i] == h.a) hit = 1;
        if (hit) nb++;
        else begin
          used.push_back(h.a);
          exp_enb[k]  = 1'b1;
          exp_addr[k] = h.a;
          exp_din[k]  = h.d;
          void'(q[k].pop_front());
        end
      end
    end
    for (int k = 0; k < 4; k++) if (acc[k]) q[k].push_back('{a: ain[k], d: din[k]});
`ifdef WSCHED_COLL_CNT_EN
    exp_coll = (exp_coll + nb > 65535) ? 65535 : exp_coll + nb;
`endif
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    vin = '0;
    ain = '0;
    din = '0;
  endtask

  int acc2;
`ifdef WSCHED_COLL_CNT_EN
  int c0;
`endif

  initial begin
    clr();
    model_reset();
    @(negedge clk);
    chk("rst_enb", enb, 4'h0);
    chk("rst_addr1", w_addr_1, 11'h0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_rdy", rdy, 4'hF);
    rst = 1'b0;
    @(negedge clk);

    // T1 single write
    vin[0] = 1'b1; ain[0] = 11'h005; din[0] = 32'hA5A5A5A5;
    step();
    clr();
    step();
    chk("t1_enb", enb, 4'b0001);
    chk("t1_addr", w_addr_1, 11'h005);
    chk("t1_din", w_din_1, 32'hA5A5A5A5);
    step();
    chk("t1_idle", idle, 1'b1);

    // T2 four distinct addresses
    for (int k = 0; k < 4; k++) begin
      vin[k] = 1'b1; ain[k] = 11'(k + 1); din[k] = 32'(k + 100);
    end
    step();
    clr();
    step();
    chk("t2_enb", enb, 4'hF);
    chk("t2_addr4", w_addr_4, 11'h004);
`ifdef WSCHED_COLL_CNT_EN
    chk("t2_coll", coll_cnt, 16'd0);
    c0 = int'(coll_cnt);
`endif

    // T3 lanes 1,3,4 share one address
    vin = 4'b1101; ain = {11'h010, 11'h010, 11'h0, 11'h010}; din = {32'd4, 32'd3, 32'd0, 32'd1};
    step();
    clr();
    step();
    chk("t3_a", enb, 4'b0001);
    step();
    chk("t3_b", enb, 4'b0100);
    step();
    chk("t3_c", enb, 4'b1000);
    chk("t3_din4", w_din_4, 32'd4);
`ifdef WSCHED_COLL_CNT_EN
    chk("t3_coll", int'(coll_cnt) - c0, 3);
`endif
    step();

    // T4 lane 2 held back by a steady stream on lane 1
    acc2 = 0;
    for (int c = 0; c < 14; c++) begin
      vin[0] = (c < 9); ain[0] = 11'h020; din[0] = 32'(c);
      vin[1] = (c < 11); ain[1] = 11'h020; din[1] = 32'h2000 + 32'(acc2);
      if (vin[1] && q[1].size() < DEPTH) acc2++;
      step();
      if (c == 7) chk("t4_full", in_ready_2, 1'b0);
    end
    clr();
    for (int c = 0; c < 8; c++) step();
    chk("t4_idle", idle, 1'b1);

    // T5 ten back-to-back writes on lane 4
    for (int c = 0; c < 10; c++) begin
      vin[3] = 1'b1; ain[3] = 11'(c); din[3] = 32'h4000 + 32'(c);
      step();
    end
    clr();
    step();
    chk("t5_last", w_addr_4, 11'h009);
    step();

    // T6 reset with entries queued on lane 2 behind lane 1
    for (int c = 0; c < 4; c++) begin
      vin[0] = 1'b1; ain[0] = 11'h030; din[0] = 32'(c);
      vin[1] = (c < 3); ain[1] = 11'h030; din[1] = 32'h6000 + 32'(c);
      step();
    end
    chk("t6_queued", q[1].size(), 3);
    rst = 1'b1;
    #1;
    chk("t6_enb", enb, 4'h0);
    chk("t6_idle", idle, 1'b1);
    chk("t6_rdy", rdy, 4'hF);
    model_reset();
    clr();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) step();

    // randomised traffic with a narrow address pool to force collisions
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 4; k++) begin
        vin[k] = ($urandom_range(0, 99) < 60);
        ain[k] = ($urandom_range(0, 9) < 7) ? 11'($urandom_range(0, 3)) : 11'($urandom);
        din[k] = $urandom;
      end
      step();
    end
    clr();
    for (int c = 0; c < 20; c++) step();
    chk("end_idle", idle, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
